// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
package pipe_pkg;

  // Memory-handshake FSM state encoding.
  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  // Architectural zero register; writes to it never create a hazard.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Which pipeline event wins arbitration in a given cycle.
  typedef enum logic [1:0] {
    EV_NONE      = 2'd0,
    EV_FLUSH     = 2'd1,
    EV_LOAD_USE  = 2'd2,
    EV_MEM_STALL = 2'd3
  } pipe_event_t;

  // Bundle of the pipeline-control strobes driven by the controller.
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_noop;
    logic pipe_hold;
  } pipe_ctrl_t;

  // Pick the single winning event: memory stall beats load-use beats flush.
  function automatic pipe_event_t resolve_event(input logic mem_stall,
                                                input logic load_use,
                                                input logic branch);
    pipe_event_t ev;
    ev = EV_NONE;
    if (mem_stall) begin
      ev = EV_MEM_STALL;
    end else if (load_use) begin
      ev = EV_LOAD_USE;
    end else if (branch) begin
      ev = EV_FLUSH;
    end
    return ev;
  endfunction

  // Translate the winning event into the control strobes it implies.
  function automatic pipe_ctrl_t ctrl_for_event(input pipe_event_t ev);
    pipe_ctrl_t c;
    c.pc_write   = 1'b1;
    c.ifid_write = 1'b1;
    c.ifid_flush = 1'b0;
    c.idex_noop  = 1'b0;
    c.pipe_hold  = 1'b0;
    case (ev)
      EV_MEM_STALL: begin
        c.pc_write   = 1'b0;
        c.ifid_write = 1'b0;
        c.pipe_hold  = 1'b1;
      end
      EV_LOAD_USE: begin
        c.pc_write   = 1'b0;
        c.ifid_write = 1'b0;
        c.idex_noop  = 1'b1;
      end
      EV_FLUSH: begin
        c.ifid_flush = 1'b1;
      end
      default: begin
        c.pc_write   = 1'b1;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipe_control_sat_counter.sv
// Saturating event counter with a synchronous clear that overrides increment.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Count one per qualifying cycle, sticking at all-ones; clear wins over inc.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end
  end

endmodule

// File: rtl/pipe_control.sv
// Pipeline hazard and memory-stall controller for a 5-stage in-order core.
module pipe_control
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_Rs1_i,
  input  logic [4:0]       ID_Rs2_i,
  input  logic [4:0]       EX_Rd_i,
  input  logic             EX_MemRead_i,
  input  logic             Branch_i,
  input  logic             Mem_req_i,
  input  logic             Mem_ack_i,
  input  logic             Cnt_clr_i,
  output logic             PCWrite_o,
  output logic             IFID_Write_o,
  output logic             IFID_Flush_o,
  output logic             IDEX_NoOp_o,
  output logic             Pipe_Hold_o,
  output logic             Mem_busy_o,
  output logic [CNT_W-1:0] LU_cnt_o,
  output logic [CNT_W-1:0] MS_cnt_o,
  output logic [CNT_W-1:0] FL_cnt_o
);

  logic [0:0]  state;
  logic [0:0]  state_next;
  logic        load_use;
  logic        mem_stall;
  pipe_event_t win_event;
  pipe_ctrl_t  ctrl;

  // Detect hazards and arbitrate them; the ack cycle itself is not a stall,
  // so a same-cycle ack costs nothing and a late ack costs one cycle per wait.
  always_comb begin
    load_use  = EX_MemRead_i && (EX_Rd_i != REG_ZERO) &&
                ((EX_Rd_i == ID_Rs1_i) || (EX_Rd_i == ID_Rs2_i));
    mem_stall = 1'b0;
    if (state == ST_RUN) begin
      mem_stall = Mem_req_i && !Mem_ack_i;
    end else begin
      mem_stall = !Mem_ack_i;
    end
    win_event = resolve_event(mem_stall, load_use, Branch_i);
    ctrl      = ctrl_for_event(win_event);
  end

  assign PCWrite_o    = ctrl.pc_write;
  assign IFID_Write_o = ctrl.ifid_write;
  assign IFID_Flush_o = ctrl.ifid_flush;
  assign IDEX_NoOp_o  = ctrl.idex_noop;
  assign Pipe_Hold_o  = ctrl.pipe_hold;

  // Next-state logic: enter the wait state on an unacknowledged request and
  // leave it only on ack; an ack with no outstanding request is ignored.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        if (Mem_req_i && !Mem_ack_i) begin
          state_next = ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        if (Mem_ack_i) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // State register; reset drops any in-flight memory wait.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  assign Mem_busy_o = (state == ST_MEM_WAIT);

  // The memory side must keep requesting until it acknowledges.
  property p_req_held_in_wait;
    @(posedge clk_i) disable iff (rst_i)
      ((state == ST_MEM_WAIT) && !Mem_ack_i) |-> Mem_req_i;
  endproperty
  a_req_held_in_wait: assert property (p_req_held_in_wait);

  sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (win_event == EV_LOAD_USE),
    .clr   (Cnt_clr_i),
    .count (LU_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_ms_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (win_event == EV_MEM_STALL),
    .clr   (Cnt_clr_i),
    .count (MS_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_fl_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (win_event == EV_FLUSH),
    .clr   (Cnt_clr_i),
    .count (FL_cnt_o)
  );

endmodule

// File: tb/tb_pipe_control.sv
// Scoreboard bench for pipe_control with hand-computed per-cycle expectations.
module tb_pipe_control;

  localparam int CNT_W = 4;

  // Control strobe patterns as {PCWrite, IFID_Write, IFID_Flush, IDEX_NoOp, Pipe_Hold}.
  localparam logic [4:0] C_NONE = 5'b11000;
  localparam logic [4:0] C_LU   = 5'b00010;
  localparam logic [4:0] C_MS   = 5'b00001;
  localparam logic [4:0] C_FL   = 5'b11100;

  typedef struct packed {
    int         id;
    logic [4:0] ctl;
    logic       busy;
    logic [3:0] lu;
    logic [3:0] ms;
    logic [3:0] fl;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [4:0]       rd;
  logic             mem_read;
  logic             branch;
  logic             mem_req;
  logic             mem_ack;
  logic             cnt_clr;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_noop;
  logic             pipe_hold;
  logic             mem_busy;
  logic [CNT_W-1:0] lu_cnt;
  logic [CNT_W-1:0] ms_cnt;
  logic [CNT_W-1:0] fl_cnt;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  pipe_control #(.CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .ID_Rs1_i     (rs1),
    .ID_Rs2_i     (rs2),
    .EX_Rd_i      (rd),
    .EX_MemRead_i (mem_read),
    .Branch_i     (branch),
    .Mem_req_i    (mem_req),
    .Mem_ack_i    (mem_ack),
    .Cnt_clr_i    (cnt_clr),
    .PCWrite_o    (pc_write),
    .IFID_Write_o (ifid_write),
    .IFID_Flush_o (ifid_flush),
    .IDEX_NoOp_o  (idex_noop),
    .Pipe_Hold_o  (pipe_hold),
    .Mem_busy_o   (mem_busy),
    .LU_cnt_o     (lu_cnt),
    .MS_cnt_o     (ms_cnt),
    .FL_cnt_o     (fl_cnt)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input int id, input string name,
                             input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL step %0d %s: got %0h, expected %0h", id, name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge and queue the
  // outputs expected while those inputs are held.
  task automatic applyStimulus(input int id,
                               input logic [4:0] s_rs1, input logic [4:0] s_rs2,
                               input logic [4:0] s_rd,  input logic s_mem_read,
                               input logic s_branch, input logic s_req, input logic s_ack,
                               input logic s_clr, input logic s_rst,
                               input logic [4:0] e_ctl, input logic e_busy,
                               input logic [3:0] e_lu, input logic [3:0] e_ms,
                               input logic [3:0] e_fl);
    exp_t e;
    @(posedge clk);
    #1;
    rs1      = s_rs1;
    rs2      = s_rs2;
    rd       = s_rd;
    mem_read = s_mem_read;
    branch   = s_branch;
    mem_req  = s_req;
    mem_ack  = s_ack;
    cnt_clr  = s_clr;
    rst      = s_rst;
    e.id   = id;
    e.ctl  = e_ctl;
    e.busy = e_busy;
    e.lu   = e_lu;
    e.ms   = e_ms;
    e.fl   = e_fl;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle that has a queued expectation, compare mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput(e.id, "ctrl", {27'd0, pc_write, ifid_write, ifid_flush, idex_noop, pipe_hold},
                  {27'd0, e.ctl});
      checkOutput(e.id, "mem_busy", {31'd0, mem_busy}, {31'd0, e.busy});
      checkOutput(e.id, "lu_cnt", {28'd0, lu_cnt}, {28'd0, e.lu});
      checkOutput(e.id, "ms_cnt", {28'd0, ms_cnt}, {28'd0, e.ms});
      checkOutput(e.id, "fl_cnt", {28'd0, fl_cnt}, {28'd0, e.fl});
    end
  end

  initial begin
    rst = 1'b1; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; mem_read = 1'b0;
    branch = 1'b0; mem_req = 1'b0; mem_ack = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);

    //            id  rs1   rs2   rd    ld br rq ak cl rs  ctl     bsy lu     ms     fl
    applyStimulus(1,  5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 4'd0, 4'd0, 4'd0);
    applyStimulus(2,  5'd5, 5'd0, 5'd5, 1, 0, 0, 0, 0, 0, C_LU,   0, 4'd0, 4'd0, 4'd0);
    applyStimulus(3,  5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 4'd1, 4'd0, 4'd0);
    applyStimulus(4,  5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, 0, C_NONE, 0, 4'd1, 4'd0, 4'd0);
    applyStimulus(5,  5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 4'd1, 4'd0, 4'd0);
    applyStimulus(6,  5'd3, 5'd7, 5'd7, 1, 0, 0, 0, 0, 0, C_LU,   0, 4'd1, 4'd0, 4'd0);
    applyStimulus(7,  5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 4'd2, 4'd0, 4'd0);
    applyStimulus(8,  5'd5, 5'd0, 5'd5, 0, 0, 0, 0, 0, 0, C_NONE, 0, 4'd2, 4'd0, 4'd0);
    applyStimulus(9,  5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0, 0, C_FL,   0, 4'd2, 4'd0, 4'd0);
    applyStimulus(10, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 4'd2, 4'd0, 4'd1);
    // Request held, ack on the fourth cycle: three held cycles.
    applyStimulus(11, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0, C_MS,   0, 4'd2, 4'd0, 4'd1);
    applyStimulus(12, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0, C_MS,   1, 4'd2, 4'd1, 4'd1);
    applyStimulus(13, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 0, 0, C_MS,   1, 4'd2, 4'd2, 4'd1);
    applyStimulus(14, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, 0, C_NONE, 1, 4'd2, 4'd3, 4'd1);
    applyStimulus(15, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 4'd2, 4'd3, 4'd1);
    // Same-cycle ack, then a stray ack with no request.
    applyStimulus(16, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, 0, C_NONE, 0, 4'd2, 4'd3, 4'd1);
    applyStimulus(17, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 4'd2, 4'd3, 4'd1);
    applyStimulus(18, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, C_NONE, 0, 4'd2, 4'd3, 4'd1);
    // Branch loses to load-use.
    applyStimulus(19, 5'd5, 5'd0, 5'd5, 1, 1, 0, 0, 0, 0, C_LU,   0, 4'd2, 4'd3, 4'd1);
    applyStimulus(20, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 4'd3, 4'd3, 4'd1);
    // Load-use loses to mem stall, then shows up in the ack cycle.
    applyStimulus(21, 5'd5, 5'd0, 5'd5, 1, 0, 1, 0, 0, 0, C_MS,   0, 4'd3, 4'd3, 4'd1);
    applyStimulus(22, 5'd5, 5'd0, 5'd5, 1, 0, 1, 1, 0, 0, C_LU,   1, 4'd3, 4'd4, 4'd1);
    applyStimulus(23, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 4'd4, 4'd4, 4'd1);
    // Twenty load-use cycles drive the 4-bit counter into saturation.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(24 + i, 5'd9, 5'd0, 5'd9, 1, 0, 0, 0, 0, 0, C_LU, 0,
                    (i >= 11) ? 4'd15 : 4'(4 + i), 4'd4, 4'd1);
    end
    applyStimulus(44, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 4'd15, 4'd4, 4'd1);
    // Clear coincides with a hazard: clear wins.
    applyStimulus(45, 5'd9, 5'd0, 5'd9, 1, 0, 0, 0, 1, 0, C_LU,   0, 4'd15, 4'd4, 4'd1);
    applyStimulus(46, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 4'd0,  4'd0, 4'd0);
    // Reset while waiting on memory.
    applyStimulus(47, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0, C_MS,   0, 4'd0, 4'd0, 4'd0);
    applyStimulus(48, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0, C_MS,   1, 4'd0, 4'd1, 4'd0);
    applyStimulus(49, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 1, C_MS,   1, 4'd0, 4'd2, 4'd0);
    applyStimulus(50, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 4'd0, 4'd0, 4'd0);

    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    checkOutput(99, "queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
